maxpool2x2_layer1: RTL and testbench
====================================

// Module: maxpool2x2_layer1
// PURPOSE
//   Consumer of the 8-channel conv layer-1 output stream. Applies a 2x2, stride-2 max-pool per channel
//   to a raster-ordered IN_W x IN_H feature map and emits an (IN_W/2) x (IN_H/2) pooled stream.
//   Sits directly after conv2d_layer1 and feeds the layer-2 line buffer.
// PARAMETERS
//   IN_W     28  input feature-map width (even; odd widths are unsupported)
//   IN_H     28  input feature-map height (even)
//   CH       8   channels (fixed by port list; must stay 8)
//   DATA_W   8   per-channel sample width, unsigned
// PORTS
//   clk        in   1       single clock, rising edge
//   rst        in   1       asynchronous, active-high reset
//   in_valid   in   1       one input pixel (all channels) present this cycle
//   in_ch0..7  in   8 each  channel samples, unsigned (0..127 from ReLU/saturation)
//   out_valid  out  1       one pooled pixel present this cycle
//   out_pool0..7 out 8 each pooled channel samples
//   out_last   out  1       high with out_valid on the final pooled pixel of a frame
// BEHAVIOUR
//   - Reset: out_valid=0, out_last=0, out_pool*=0, col/row counters=0, hmax reg=0. Row buffer
//     contents need no reset (always written before read). Reset mid-frame discards the partial
//     frame; the next in_valid is pixel (0,0).
//   - Counters col (0..IN_W-1), row (0..IN_H-1) advance only on in_valid; bubbles freeze all state.
//     col wraps to 0 at IN_W-1 and increments row; row wraps to 0 at IN_H-1 (next frame, no gap needed).
//   - Even row, even col: hmax <= in (per channel).
//   - Even row, odd col: rowbuf[col>>1] <= max(hmax, in).
//   - Odd row, even col: hmax <= max(in, rowbuf[col>>1]).
//   - Odd row, odd col: out_pool <= max(hmax, in); out_valid<=1 next edge. Latency: 1 cycle after
//     the bottom-right pixel of the window is accepted.
//   - out_valid is a 1-cycle pulse per pooled pixel; out_pool* hold last value when out_valid=0.
//   - out_last = out_valid on window (row IN_H-1, col IN_W-1); exactly (IN_W/2)*(IN_H/2)=196
//     out_valid pulses per frame at defaults.
//   - Comparisons unsigned, per channel, no arithmetic widening; ties keep either (equal value).
//   - No backpressure: downstream must accept every out_valid.
//   - Row buffer: IN_W/2 entries x CH*DATA_W bits, one write (even row) or one read (odd row) per
//     accepted pixel; never simultaneous on the same entry.
// STRUCTURE
//   - Shared package: DATA_W, CH, typedef pix_vec_t = logic [CH-1:0][DATA_W-1:0], function
//     vmax(a,b) returning per-channel unsigned max.
//   - Sub-module pool_row_buffer (DEPTH=IN_W/2, WIDTH=CH*DATA_W): sync write, async/comb read.
//   - Top: counters, hmax register, output register, channel pack/unpack of the 8 port pairs.
// TESTING
//   1 Ramp frame: every ch = (r*28+c)&7F -> out(0,0)=29, out(0,1)=31, out(1,0)=85; 196 pulses.
//   2 Channel isolation: ch k constant k*10, pixel (0,1) ch3=127 -> out(0,0): ch3=127, others k*10.
//   3 Max position sweep: single 100 in each of the 4 window positions, rest 5 -> out=100 each time.
//   4 Random in_valid bubbles (50%) -> output sequence identical to gapless run; out_last on 196th.
//   5 Back-to-back frames, no gap -> 392 pulses, out_last twice, frame-2 values independent of frame 1.
//   6 rst asserted at pixel (13,7) then new frame -> outputs 0 during reset, 196 correct pulses after.

Source files
------------

// File: rtl/maxpool2x2_layer1_pkg.sv
// Shared types for the layer-1 max-pool: the 8-channel pixel vector and a
// per-channel unsigned max helper.
package maxpool2x2_layer1_pkg;

  localparam int DATA_W = 8;
  localparam int CH     = 8;

  typedef logic [CH-1:0][DATA_W-1:0] pix_vec_t;

  function automatic pix_vec_t vmax(input pix_vec_t a, input pix_vec_t b);
    pix_vec_t m;
    for (int i = 0; i < CH; i++) begin
      m[i] = (a[i] >= b[i]) ? a[i] : b[i];
    end
    return m;
  endfunction

endpackage

// File: rtl/maxpool2x2_layer1_pool_row_buffer.sv
// Half-width line store holding the horizontal maxima of the even row.
// Synchronous write, combinational read, shared address.
module pool_row_buffer #(
  parameter int DEPTH  = 14,
  parameter int WIDTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  // Always written on the even row before being read on the odd row, so no reset.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/maxpool2x2_layer1.sv
// 2x2 stride-2 per-channel max-pool over a raster-ordered IN_W x IN_H,
// 8-channel feature map; one registered output pulse per pooled pixel.
module maxpool2x2_layer1
  import maxpool2x2_layer1_pkg::*;
#(
  parameter int IN_W = 28,
  parameter int IN_H = 28
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_ch0,
  input  logic [DATA_W-1:0] in_ch1,
  input  logic [DATA_W-1:0] in_ch2,
  input  logic [DATA_W-1:0] in_ch3,
  input  logic [DATA_W-1:0] in_ch4,
  input  logic [DATA_W-1:0] in_ch5,
  input  logic [DATA_W-1:0] in_ch6,
  input  logic [DATA_W-1:0] in_ch7,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_pool0,
  output logic [DATA_W-1:0] out_pool1,
  output logic [DATA_W-1:0] out_pool2,
  output logic [DATA_W-1:0] out_pool3,
  output logic [DATA_W-1:0] out_pool4,
  output logic [DATA_W-1:0] out_pool5,
  output logic [DATA_W-1:0] out_pool6,
  output logic [DATA_W-1:0] out_pool7,
  output logic              out_last
);

  localparam int COL_W  = $clog2(IN_W);
  localparam int ROW_W  = $clog2(IN_H);
  localparam int ADDR_W = COL_W - 1;

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  pix_vec_t         hmax_q, hmax_d;
  pix_vec_t         out_pool_q, out_pool_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;

  pix_vec_t in_pix;
  pix_vec_t rb_wdata;
  pix_vec_t rb_rdata;
  logic     rb_we;
  logic     last_col;
  logic     last_row;

  assign in_pix   = {in_ch7, in_ch6, in_ch5, in_ch4, in_ch3, in_ch2, in_ch1, in_ch0};
  assign last_col = (col_q == COL_W'(IN_W - 1));
  assign last_row = (row_q == ROW_W'(IN_H - 1));

  pool_row_buffer #(
    .DEPTH  (IN_W / 2),
    .WIDTH  (CH * DATA_W),
    .ADDR_W (ADDR_W)
  ) u_row_buffer (
    .clk   (clk),
    .we    (rb_we),
    .addr  (col_q[COL_W-1:1]),
    .wdata (rb_wdata),
    .rdata (rb_rdata)
  );

  // Row/column parity selects which stage of the 2x2 window this pixel completes.
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    hmax_d      = hmax_q;
    out_pool_d  = out_pool_q;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    rb_we       = 1'b0;
    rb_wdata    = vmax(hmax_q, in_pix);
    if (in_valid) begin
      unique case ({row_q[0], col_q[0]})
        2'b00: hmax_d = in_pix;
        2'b01: rb_we  = 1'b1;
        2'b10: hmax_d = vmax(in_pix, rb_rdata);
        default: begin
          out_pool_d  = vmax(hmax_q, in_pix);
          out_valid_d = 1'b1;
          out_last_d  = last_col && last_row;
        end
      endcase
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      hmax_q      <= '0;
      out_pool_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      hmax_q      <= hmax_d;
      out_pool_q  <= out_pool_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_pool0 = out_pool_q[0];
  assign out_pool1 = out_pool_q[1];
  assign out_pool2 = out_pool_q[2];
  assign out_pool3 = out_pool_q[3];
  assign out_pool4 = out_pool_q[4];
  assign out_pool5 = out_pool_q[5];
  assign out_pool6 = out_pool_q[6];
  assign out_pool7 = out_pool_q[7];

endmodule

// File: tb/tb_maxpool2x2_layer1.sv
// Scoreboard bench for maxpool2x2_layer1: a frame-level reference model fills
// an expectation queue and a monitor compares every output pulse.
module tb_maxpool2x2_layer1;
  import maxpool2x2_layer1_pkg::*;

  localparam int IN_W  = 28;
  localparam int IN_H  = 28;
  localparam int OUT_W = IN_W / 2;
  localparam int OUT_H = IN_H / 2;
  localparam int NPIX  = IN_W * IN_H;
  localparam int NWIN  = OUT_W * OUT_H;

  typedef struct {
    pix_vec_t pool;
    bit       last;
  } exp_t;

  logic     clk = 1'b0;
  logic     rst;
  logic     in_valid;
  pix_vec_t in_pix;
  logic     out_valid;
  logic     out_last;
  pix_vec_t out_pix;

  exp_t     exp_q[$];
  pix_vec_t cap_q[$];
  pix_vec_t img [IN_H][IN_W];
  int       total  = 0;
  int       bad    = 0;
  int       pulses = 0;
  int       lasts  = 0;

  maxpool2x2_layer1 #(.IN_W(IN_W), .IN_H(IN_H)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ch0    (in_pix[0]),
    .in_ch1    (in_pix[1]),
    .in_ch2    (in_pix[2]),
    .in_ch3    (in_pix[3]),
    .in_ch4    (in_pix[4]),
    .in_ch5    (in_pix[5]),
    .in_ch6    (in_pix[6]),
    .in_ch7    (in_pix[7]),
    .out_valid (out_valid),
    .out_pool0 (out_pix[0]),
    .out_pool1 (out_pix[1]),
    .out_pool2 (out_pix[2]),
    .out_pool3 (out_pix[3]),
    .out_pool4 (out_pix[4]),
    .out_pool5 (out_pix[5]),
    .out_pool6 (out_pix[6]),
    .out_pool7 (out_pix[7]),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Expected pooled pixels for every window whose bottom-right pixel lies
  // within the first npix raster pixels of img.
  task automatic push_expected(input int npix);
    exp_t e;
    for (int wr = 0; wr < OUT_H; wr++) begin
      for (int wc = 0; wc < OUT_W; wc++) begin
        if ((2*wr + 1) * IN_W + 2*wc + 1 < npix) begin
          for (int ch = 0; ch < CH; ch++) begin
            int m;
            m = 0;
            for (int dr = 0; dr < 2; dr++)
              for (int dc = 0; dc < 2; dc++)
                if (int'(img[2*wr+dr][2*wc+dc][ch]) > m) m = int'(img[2*wr+dr][2*wc+dc][ch]);
            e.pool[ch] = m[7:0];
          end
          e.last = (wr == OUT_H - 1) && (wc == OUT_W - 1);
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic applyStimulus(input int npix, input bit bubbles);
    for (int p = 0; p < npix; p++) begin
      if (bubbles) begin
        while ($urandom_range(0, 1) == 1) begin
          in_valid = 1'b0;
          in_pix   = pix_vec_t'({$urandom, $urandom});
          @(negedge clk);
        end
      end
      in_valid = 1'b1;
      in_pix   = img[p / IN_W][p % IN_W];
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    checkOutput("drain_queue_empty", exp_q.size(), 0);
  endtask

  task automatic fill_random();
    for (int r = 0; r < IN_H; r++)
      for (int c = 0; c < IN_W; c++)
        for (int ch = 0; ch < CH; ch++)
          img[r][c][ch] = 8'($urandom_range(0, 255));
  endtask

  task automatic fill_const(input int v);
    for (int r = 0; r < IN_H; r++)
      for (int c = 0; c < IN_W; c++)
        for (int ch = 0; ch < CH; ch++)
          img[r][c][ch] = 8'(v);
  endtask

  task automatic check_reset_outputs(input string name);
    checkOutput({name, "_valid"}, out_valid, 0);
    checkOutput({name, "_last"}, out_last, 0);
    checkOutput({name, "_pool"}, out_pix, 0);
  endtask

  // Monitor: every output pulse is matched against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (out_valid) begin
          pulses++;
          if (out_last) lasts++;
          cap_q.push_back(out_pix);
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_pulse", 1, 0);
          end else begin
            e = exp_q.pop_front();
            checkOutput("pool", out_pix, e.pool);
            checkOutput("last", out_last, e.last);
          end
        end else begin
          checkOutput("last_without_valid", out_last, 0);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int p0;
    int l0;
    pix_vec_t v;

    rst      = 1'b1;
    in_valid = 1'b0;
    in_pix   = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] ramp frame");
    for (int r = 0; r < IN_H; r++)
      for (int c = 0; c < IN_W; c++)
        for (int ch = 0; ch < CH; ch++)
          img[r][c][ch] = 8'((r * IN_W + c) & 8'h7F);
    cap_q.delete();
    p0 = pulses;
    l0 = lasts;
    push_expected(NPIX);
    applyStimulus(NPIX, 1'b0);
    drain();
    checkOutput("ramp_pulses", pulses - p0, NWIN);
    checkOutput("ramp_lasts", lasts - l0, 1);
    checkOutput("ramp_capture_size", cap_q.size(), NWIN);
    if (cap_q.size() >= 15) begin
      checkOutput("ramp_out00", cap_q[0][0], 29);
      checkOutput("ramp_out01", cap_q[1][0], 31);
      checkOutput("ramp_out10", cap_q[14][0], 85);
    end

    $display("[TB] channel isolation");
    for (int r = 0; r < IN_H; r++)
      for (int c = 0; c < IN_W; c++)
        for (int ch = 0; ch < CH; ch++)
          img[r][c][ch] = 8'(ch * 10);
    img[0][1][3] = 8'd127;
    for (int ch = 0; ch < CH; ch++) v[ch] = 8'(ch * 10);
    v[3] = 8'd127;
    cap_q.delete();
    push_expected(NPIX);
    applyStimulus(NPIX, 1'b0);
    drain();
    if (cap_q.size() > 0) checkOutput("isolation_out00", cap_q[0], v);
    else checkOutput("isolation_capture", cap_q.size(), 1);

    $display("[TB] max position sweep");
    for (int pos = 0; pos < 4; pos++) begin
      fill_const(5);
      for (int wr = 0; wr < OUT_H; wr++)
        for (int wc = 0; wc < OUT_W; wc++)
          for (int ch = 0; ch < CH; ch++)
            img[2*wr + pos/2][2*wc + pos%2][ch] = 8'd100;
      cap_q.delete();
      push_expected(NPIX);
      applyStimulus(NPIX, 1'b0);
      drain();
      if (cap_q.size() == NWIN) begin
        checkOutput("sweep_first", cap_q[0], {CH{8'd100}});
        checkOutput("sweep_final", cap_q[NWIN-1], {CH{8'd100}});
      end else begin
        checkOutput("sweep_capture", cap_q.size(), NWIN);
      end
    end

    $display("[TB] random frame with bubbles");
    fill_random();
    p0 = pulses;
    l0 = lasts;
    push_expected(NPIX);
    applyStimulus(NPIX, 1'b1);
    drain();
    checkOutput("bubble_pulses", pulses - p0, NWIN);
    checkOutput("bubble_lasts", lasts - l0, 1);

    $display("[TB] back-to-back frames");
    p0 = pulses;
    l0 = lasts;
    fill_random();
    push_expected(NPIX);
    applyStimulus(NPIX, 1'b0);
    fill_random();
    push_expected(NPIX);
    applyStimulus(NPIX, 1'b0);
    drain();
    checkOutput("b2b_pulses", pulses - p0, 2 * NWIN);
    checkOutput("b2b_lasts", lasts - l0, 2);

    $display("[TB] mid-frame reset");
    fill_random();
    push_expected(13 * IN_W + 7);
    applyStimulus(13 * IN_W + 7, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("partial_queue_empty", exp_q.size(), 0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_reset_outputs("midreset");
    end
    rst = 1'b0;
    @(negedge clk);
    fill_random();
    p0 = pulses;
    l0 = lasts;
    push_expected(NPIX);
    applyStimulus(NPIX, 1'b1);
    drain();
    checkOutput("after_reset_pulses", pulses - p0, NWIN);
    checkOutput("after_reset_lasts", lasts - l0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
